// File: rtl/div_real_seq.sv
// Sequential fixed-point divider: c = (a scaled to the quotient exponent) / b, truncated
// toward zero, with saturation and a divide-by-zero flag, fixed c_width+1 cycle compute phase.
module div_real_seq #(
  parameter int a_width    = 16,
  parameter int a_exponent = -8,
  parameter int b_width    = 17,
  parameter int b_exponent = -9,
  parameter int c_width    = 18,
  parameter int c_exponent = -10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [a_width-1:0] a,
  input  logic signed [b_width-1:0] b,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [c_width-1:0] c,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      div_zero,
  output logic                      overflow
);
  localparam int SHIFT = a_exponent - b_exponent - c_exponent;
  localparam int SHP   = (SHIFT > 0) ? SHIFT : 0;
  localparam int SHN   = (SHIFT < 0) ? -SHIFT : 0;
  localparam int NW    = a_width + SHP + 1;
  localparam int WW    = (NW > b_width + c_width) ? NW : b_width + c_width;
  localparam int CW    = $clog2(c_width + 1);
  localparam logic [c_width-1:0] C_MAX = {1'b0, {(c_width-1){1'b1}}};
  localparam logic [c_width-1:0] C_MIN = {1'b1, {(c_width-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;

  logic [CW-1:0]             cnt;
  logic signed [a_width-1:0] a_r;
  logic signed [b_width-1:0] b_r;
  logic [WW-1:0]             rem, dreg;
  logic [c_width-2:0]        q;
  logic                      neg, bz, ovf;

  logic signed [NW-1:0]      a_ext, n_full;
  logic [NW-1:0]             n_mag;
  logic signed [b_width:0]   b_ext;
  logic [b_width:0]          b_mag;
  logic [WW-1:0]             d_init;
  logic                      neg_c, bz_c, ovf_c, ge;
  logic [c_width-1:0]        q_n, res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = CALC;
      CALC:    if (cnt == CW'(c_width)) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Magnitudes carry one spare bit so the most-negative operand negates cleanly.
  always_comb begin
    a_ext  = {{(SHP+1){a_r[a_width-1]}}, a_r};
    n_full = (a_ext <<< SHP) >>> SHN;
    n_mag  = n_full[NW-1] ? NW'(-n_full) : NW'(n_full);
    b_ext  = {b_r[b_width-1], b_r};
    b_mag  = b_ext[b_width] ? (b_width+1)'(-b_ext) : (b_width+1)'(b_ext);
    d_init = WW'(b_mag) << (c_width-1);
    neg_c  = a_r[a_width-1] ^ b_r[b_width-1];
    bz_c   = (b_r == '0);
    // Negative results may reach magnitude 2^(c_width-1), one step further than positive ones.
    ovf_c  = ~bz_c & (WW'(n_mag) >= (neg_c ? d_init + WW'(b_mag) : d_init));
    ge     = (rem >= dreg);
    q_n    = {q, ge};
    if (bz)       res = a_r[a_width-1] ? C_MIN : C_MAX;
    else if (ovf) res = neg ? C_MIN : C_MAX;
    else          res = neg ? -q_n : q_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; a_r <= '0; b_r <= '0; rem <= '0; dreg <= '0; q <= '0;
      neg <= 1'b0; bz <= 1'b0; ovf <= 1'b0;
      c <= '0; div_zero <= 1'b0; overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= b;
          cnt <= '0;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == '0) begin
            rem  <= WW'(n_mag);
            dreg <= d_init;
            q    <= '0;
            neg  <= neg_c;
            bz   <= bz_c;
            ovf  <= ovf_c;
          end else begin
            rem  <= ge ? rem - dreg : rem;
            dreg <= dreg >> 1;
            q    <= q_n[c_width-2:0];
            if (cnt == CW'(c_width)) begin
              c        <= res;
              div_zero <= bz;
              overflow <= ovf;
            end
          end
        end
        DONE: if (out_ready) begin
          c        <= '0;
          div_zero <= 1'b0;
          overflow <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_real_seq.sv
// Bench for div_real_seq: directed literal cases plus randomized traffic against an
// arithmetic reference model with per-cycle handshake/latency/flag checking.
module tb_div_real_seq;
  localparam int AW = 16, BW = 17, CWD = 18;
  localparam int SHIFT = (-8) - (-9) - (-10);
  localparam int LAT = CWD + 1;
  localparam longint CMAX = (longint'(1) <<< (CWD-1)) - 1;
  localparam longint CMIN = -(longint'(1) <<< (CWD-1));

  logic clk, rst, in_valid, in_ready, out_valid, out_ready, div_zero, overflow;
  logic signed [AW-1:0]  a;
  logic signed [BW-1:0]  b;
  logic signed [CWD-1:0] c;

  int n_cmp = 0, n_bad = 0;

  div_real_seq dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .div_zero(div_zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the real-valued definition.
  function automatic void model(input longint av, input longint bv,
                                output longint ec, output bit edz, output bit eov);
    longint n, qq;
    n = (SHIFT >= 0) ? av * (longint'(1) <<< SHIFT) : (av >>> (-SHIFT));
    edz = 1'b0; eov = 1'b0;
    if (bv == 0) begin
      edz = 1'b1;
      ec  = (av < 0) ? CMIN : CMAX;
    end else begin
      qq = n / bv;
      if (qq > CMAX)      begin ec = CMAX; eov = 1'b1; end
      else if (qq < CMIN) begin ec = CMIN; eov = 1'b1; end
      else ec = qq;
    end
  endfunction

  // Per-cycle checker: outputs sampled at negedge, inputs seen there are the ones the next edge uses.
  bit     pend = 1'b0, rst_q = 1'b0, exp_ov;
  int     cyc = 0, due = 0;
  longint e_c;
  bit     e_dz, e_ov;

  always @(negedge clk) begin
    cyc++;
    exp_ov = pend && (cyc >= due);
    chk("in_ready", in_ready, !pend);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("c", c, e_c);
      chk("div_zero", div_zero, e_dz);
      chk("overflow", overflow, e_ov);
    end else begin
      chk("div_zero_idle", div_zero, 0);
      chk("overflow_idle", overflow, 0);
    end
    if (rst_q) chk("c_after_rst", c, 0);
    rst_q = rst;
    if (rst) pend = 1'b0;
    else if (!pend && in_valid) begin
      pend = 1'b1;
      model(a, b, e_c, e_dz, e_ov);
      due = cyc + LAT + 1;
    end else if (exp_ov && out_ready) pend = 1'b0;
  end

  task automatic op(input longint av, input longint bv, input longint ec,
                    input bit edz, input bit eov, input int hold);
    int t;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!in_ready && t < 50);
    chk("op_ready", in_ready, 1);
    a = AW'(av); b = BW'(bv); in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 40) begin
      @(posedge clk); #1; t++;
      in_valid = (hold != 0) && t[0];
      a = AW'($urandom); b = BW'($urandom);
    end
    chk("op_out_valid", out_valid, 1);
    chk("op_latency", t, LAT);
    chk("op_c", c, ec);
    chk("op_div_zero", div_zero, edz);
    chk("op_overflow", overflow, eov);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      in_valid = i[0];
      a = AW'($urandom);
      chk("hold_c", c, ec);
      chk("hold_dz", div_zero, edz);
      chk("hold_ov", overflow, eov);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_c", c, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);

    op(768, 768, 2048, 0, 0, 0);
    op(-256, 128, -4096, 0, 0, 0);
    op(256, 1536, 341, 0, 0, 0);
    op(25600, 1, 131071, 0, 1, 0);
    op(-32768, -1, 131071, 0, 1, 0);
    op(-512, 0, -131072, 1, 0, 0);
    op(-256, 128, -4096, 0, 0, 5);

    // Reset in the middle of an operation: edge k accepts, reset sampled at edge k+7.
    @(posedge clk); #1;
    a = 768; b = 768; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_c", c, 0);
    repeat (25) begin
      @(posedge clk); #1;
      chk("midrst_no_result", out_valid, 0);
    end
    op(768, 768, 2048, 0, 0, 0);

    // Random traffic; the per-cycle checker carries all expectations here.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 3) != 0;
      out_ready = ($urandom % 4) != 0;
      rst       = ($urandom % 500) == 0;
      a = AW'($urandom);
      b = BW'($urandom);
      case ($urandom % 8)
        0: b = '0;
        1: a = {1'b1, {(AW-1){1'b0}}};
        2: b = ($urandom % 2) ? BW'(1) : -BW'(1);
        3: b = {1'b1, {(BW-1){1'b0}}};
        4: b = BW'($urandom % 64) - BW'(32);
        default: ;
      endcase
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
